// File: rtl/memory_access_stage_if.sv
// EX->MEM request bundle and MEM->WB result bundle for the MEM pipeline stage.
// Flow control: XM_* is offered every cycle. M_stall high means "not ready": the producer
// holds XM_* (and the upstream stages) stable until M_stall is low. The op is consumed on
// the first rising edge where M_stall is low.
interface memory_access_stage_if;
  logic [31:0] ALUout;
  logic [31:0] XM_storeData;
  logic [4:0]  XM_RD;
  logic        XM_lwFlag;
  logic        XM_swFlag;
  logic [2:0]  XM_compareFlag;

  logic [31:0] MW_ALUout;
  logic [31:0] MW_memData;
  logic [4:0]  MW_RD;
  logic        MW_lwFlag;
  logic        M_stall;
  logic        M_err;
  logic        dbg_busy;

  modport master (
    output ALUout, XM_storeData, XM_RD, XM_lwFlag, XM_swFlag, XM_compareFlag,
    input  MW_ALUout, MW_memData, MW_RD, MW_lwFlag, M_stall, M_err, dbg_busy
  );

  modport slave (
    input  ALUout, XM_storeData, XM_RD, XM_lwFlag, XM_swFlag, XM_compareFlag,
    output MW_ALUout, MW_memData, MW_RD, MW_lwFlag, M_stall, M_err, dbg_busy
  );
endinterface

// File: rtl/memory_access_stage.sv
// MEM stage: lw/sw against an internal word-addressed data memory with MEM_LAT wait
// states, single-cycle pass-through for non-memory ops, and a MEM->WB output register.
module memory_access_stage #(
  parameter int ADDR_W  = 6,
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  memory_access_stage_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT_START = 4'(MEM_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       mw_aluout_q, mw_aluout_d;
  logic [31:0]       mw_memdata_q, mw_memdata_d;
  logic [4:0]        mw_rd_q, mw_rd_d;
  logic              mw_lwflag_q, mw_lwflag_d;
  logic              m_err_q, m_err_d;
  logic [31:0]       mem_q [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              mem_op;
  logic              op_err;
  logic              stall;
  logic              complete;
  logic              mem_we;

  assign idx    = bus.ALUout[ADDR_W+1:2];
  assign mem_op = bus.XM_lwFlag | bus.XM_swFlag;
  assign op_err = (bus.XM_lwFlag & bus.XM_swFlag) | (mem_op & (bus.ALUout[1:0] != 2'b00));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mw_aluout_d  = mw_aluout_q;
    mw_memdata_d = mw_memdata_q;
    mw_rd_d      = mw_rd_q;
    mw_lwflag_d  = mw_lwflag_q;
    m_err_d      = 1'b0;
    stall        = 1'b0;
    complete     = 1'b0;
    mem_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_err) begin
          m_err_d     = 1'b1;
          mw_rd_d     = 5'd0;
          mw_lwflag_d = 1'b0;
        end else if (!mem_op) begin
          mw_aluout_d = bus.ALUout;
          mw_lwflag_d = 1'b0;
          // Branches and jumps flow through the pipe but never write a register.
          mw_rd_d     = (bus.XM_compareFlag == 3'd1 || bus.XM_compareFlag == 3'd2)
                        ? 5'd0 : bus.XM_RD;
        end else if (MEM_LAT == 0) begin
          complete = 1'b1;
        end else begin
          stall       = 1'b1;
          state_d     = BUSY;
          cnt_d       = LAT_START;
          mw_rd_d     = 5'd0;
          mw_lwflag_d = 1'b0;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          stall       = 1'b1;
          cnt_d       = cnt_q - 4'd1;
          mw_rd_d     = 5'd0;
          mw_lwflag_d = 1'b0;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // XM_* is held while stalled, so the completion edge sees the original request.
    if (complete) begin
      mw_aluout_d = bus.ALUout;
      if (bus.XM_swFlag) begin
        mem_we      = 1'b1;
        mw_rd_d     = 5'd0;
        mw_lwflag_d = 1'b0;
      end else begin
        mw_memdata_d = mem_q[idx];
        mw_rd_d      = bus.XM_RD;
        mw_lwflag_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      mw_aluout_q  <= 32'd0;
      mw_memdata_q <= 32'd0;
      mw_rd_q      <= 5'd0;
      mw_lwflag_q  <= 1'b0;
      m_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mw_aluout_q  <= mw_aluout_d;
      mw_memdata_q <= mw_memdata_d;
      mw_rd_q      <= mw_rd_d;
      mw_lwflag_q  <= mw_lwflag_d;
      m_err_q      <= m_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (mem_we) begin
      mem_q[idx] <= bus.XM_storeData;
    end
  end

  // Stall is gated by reset so an aborted access releases upstream immediately.
  assign bus.M_stall    = stall & rst_n;
  assign bus.MW_ALUout  = mw_aluout_q;
  assign bus.MW_memData = mw_memdata_q;
  assign bus.MW_RD      = mw_rd_q;
  assign bus.MW_lwFlag  = mw_lwflag_q;
  assign bus.M_err      = m_err_q;
  assign bus.dbg_busy   = (state_q == BUSY);
endmodule
